sensor_conditioner: RTL

- Upstream front end for the pad sensors.
- Takes raw asynchronous sensor pins, synchronizes and debounces each channel, and drives the clean 32-bit `sensor_input` word consumed by the top level (VGA controller and processor address 0).
- Also queues 0→1 sensor transitions as an event stream, with a valid/ready handshake, for the processor.

---
 rtl/sensor_pkg.sv | 19 +
 rtl/sensor_debounce_cell.sv | 51 +++++
 rtl/sensor_conditioner.sv | 114 +++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared widths, presenter state encoding and lowest-set-bit encoder for the sensor front end.
package sensor_pkg;

  localparam int SENSOR_WORD_W = 32;
  localparam int EVENT_ID_W    = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } pres_state_t;

  function automatic logic [EVENT_ID_W-1:0] lowest_index(input logic [SENSOR_WORD_W-1:0] v);
    lowest_index = '0;
    for (int i = SENSOR_WORD_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = EVENT_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/sensor_debounce_cell.sv
// One channel: 2-flop synchronizer, debounce counter and stable bit; stable level lands DEBOUNCE_CYCLES+2 edges after sampling.
// o_toggle/o_rise are combinational and flag the edge on which the stable bit is about to change; no backpressure.
module sensor_debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_toggle,
  output logic o_rise
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_accept;

  assign w_differs = (r_sync2 != r_q);
  assign w_accept  = w_differs && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_q     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_q   <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_q;
  assign o_toggle = w_accept;
  assign o_rise   = w_accept && r_sync2;

endmodule

// File: rtl/sensor_conditioner.sv
// Pad sensor front end: debounced 32-bit level word plus a valid/ready stream of rising-edge events, one per cycle max.
// Events wait in a per-channel pending vector while the consumer stalls; repeats are counted in event_overflow. SENSOR_ACTIVE_LOW_EN inverts the pins.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int NUM_SENSORS     = 24,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int OVF_WIDTH       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_SENSORS-1:0]   sensor_raw,
  output logic [SENSOR_WORD_W-1:0] sensor_input,
  output logic                     sensor_change,
  output logic                     event_valid,
  output logic [EVENT_ID_W-1:0]    event_id,
  input  logic                     event_ready,
  output logic [OVF_WIDTH-1:0]     event_overflow
);

  logic [NUM_SENSORS-1:0]   w_pin;
  logic [NUM_SENSORS-1:0]   w_stable;
  logic [NUM_SENSORS-1:0]   w_toggle;
  logic [NUM_SENSORS-1:0]   w_rise;
  logic [SENSOR_WORD_W-1:0] w_rise32;
  logic [SENSOR_WORD_W-1:0] w_clr;
  logic [SENSOR_WORD_W-1:0] w_held;
  logic [SENSOR_WORD_W-1:0] w_lost;
  logic [SENSOR_WORD_W-1:0] w_set;
  logic [EVENT_ID_W-1:0]    w_next_id;
  logic                     w_any_pending;
  logic                     w_load;

  logic [SENSOR_WORD_W-1:0] r_pending;
  logic [EVENT_ID_W-1:0]    r_id;
  logic [OVF_WIDTH-1:0]     r_ovf;
  logic                     r_change;
  pres_state_t              r_state;

`ifdef SENSOR_ACTIVE_LOW_EN
  assign w_pin = ~sensor_raw;
`else
  assign w_pin = sensor_raw;
`endif

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_cell
    sensor_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_raw   (w_pin[g]),
      .o_stable(w_stable[g]),
      .o_toggle(w_toggle[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_rise32      = SENSOR_WORD_W'(w_rise);
  assign w_any_pending = |r_pending;
  assign w_next_id     = lowest_index(r_pending);
  assign w_load        = w_any_pending && ((r_state == IDLE) || event_ready);
  assign w_clr         = w_load ? (SENSOR_WORD_W'(1) << w_next_id) : '0;

  // A channel is busy if it still waits in pending (and is not moving to the presenter now)
  // or is on the output and not being taken this cycle; a new edge on a busy channel is lost.
  assign w_held = (r_pending & ~w_clr)
                | (((r_state == PRESENT) && !event_ready) ? (SENSOR_WORD_W'(1) << r_id) : '0);
  assign w_lost = w_rise32 & w_held;
  assign w_set  = w_rise32 & ~w_lost;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
      r_change  <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_change  <= |w_toggle;
      if ((|w_lost) && !(&r_ovf)) r_ovf <= r_ovf + OVF_WIDTH'(1);
      case (r_state)
        IDLE: begin
          if (w_any_pending) begin
            r_id    <= w_next_id;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (event_ready) begin
            if (w_any_pending) begin
              r_id <= w_next_id;
            end else begin
              r_id    <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_id    <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sensor_input   = SENSOR_WORD_W'(w_stable);
  assign sensor_change  = r_change;
  assign event_valid    = (r_state == PRESENT);
  assign event_id       = r_id;
  assign event_overflow = r_ovf;

endmodule
